// File: rtl/pic_pkg.sv
// Shared types, constants and rotating-priority helpers for the 8-input interrupt sequencer.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } pic_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] level;
  } rot_res_t;

  // Highest-priority set bit, scanning upward from prio_low+1 with wrap.
  function automatic rot_res_t rot_highest(input logic [7:0] vec, input logic [2:0] prio_low);
    rot_res_t   res;
    logic [2:0] idx;
    res.found = 1'b0;
    res.level = SPURIOUS_LEVEL;
    for (int i = 1; i <= NUM_IR; i++) begin
      idx = prio_low + 3'(i);
      if (!res.found && vec[idx]) begin
        res.found = 1'b1;
        res.level = idx;
      end
    end
    return res;
  endfunction

  // Rank 0 is the highest priority under the current rotation.
  function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] prio_low);
    return level - prio_low - 3'd1;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotating find-first over an 8-bit request vector.
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [7:0] i_vec,
  input  logic [2:0] i_prio_low,
  output logic [2:0] o_level,
  output logic       o_found
);

  rot_res_t w_res;

  always_comb begin
    w_res = rot_highest(i_vec, i_prio_low);
  end

  assign o_level = w_res.level;
  assign o_found = w_res.found;

endmodule

// File: rtl/pic_irq_sequencer.sv
// 8259-style interrupt sequencer: IRR capture, rotating priority, two-pulse INTA, EOI retire.
// Optional automatic EOI on the second INTA rise when built with PIC_AEOI_EN.
module pic_irq_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VEC_HI_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          irq,
  input  logic                ltim,
  input  logic [7:0]          imr,
  input  logic                smm,
  input  logic [VEC_HI_W-1:0] vec_base,
  input  logic [2:0]          prio_low,
  input  logic                inta_n,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [2:0]          eoi_level,
`ifdef PIC_AEOI_EN
  input  logic                aeoi,
`endif
  output logic                int_o,
  output logic [7:0]          vec_o,
  output logic                vec_oe,
  output logic [7:0]          irr_o,
  output logic [7:0]          isr_o,
  output logic [2:0]          ack_level,
  output logic [2:0]          dbg_state
);

  logic [SYNC_STAGES-1:0][7:0] r_irq_sync;
  logic [SYNC_STAGES-1:0]      r_inta_sync;
  logic [7:0]                  r_irq_prev;
  logic                        r_inta_prev;

  logic [7:0]  r_irr;
  logic [7:0]  r_isr;
  pic_state_t  r_state;
  logic        r_int;
  logic [7:0]  r_vec;
  logic        r_vec_oe;
  logic [2:0]  r_ack_level;
`ifdef PIC_AEOI_EN
  logic        r_ack_spur;
`endif

  logic [7:0]  w_irq_s;
  logic [7:0]  w_irq_rise;
  logic        w_inta_s;
  logic        w_inta_fall;
  logic        w_inta_rise;
  logic [7:0]  w_cand;
  logic [2:0]  w_win_level;
  logic        w_cand_found;
  logic [2:0]  w_isr_top;
  logic        w_isr_found;
  logic        w_win_valid;
  logic        w_take_ack;
  logic [7:0]  w_ack_bit;
  logic [7:0]  w_isr_clr;
  logic [7:0]  w_isr_next;

  // inta_n chain resets to 1 so a released reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_sync  <= '0;
      r_inta_sync <= '1;
      r_irq_prev  <= '0;
      r_inta_prev <= 1'b1;
    end else begin
      r_irq_sync[0]  <= irq;
      r_inta_sync[0] <= inta_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_irq_sync[i]  <= r_irq_sync[i-1];
        r_inta_sync[i] <= r_inta_sync[i-1];
      end
      r_irq_prev  <= w_irq_s;
      r_inta_prev <= w_inta_s;
    end
  end

  assign w_irq_s     = r_irq_sync[SYNC_STAGES-1];
  assign w_inta_s    = r_inta_sync[SYNC_STAGES-1];
  assign w_irq_rise  = w_irq_s & ~r_irq_prev;
  assign w_inta_fall = r_inta_prev & ~w_inta_s;
  assign w_inta_rise = ~r_inta_prev & w_inta_s;

  assign w_cand = r_irr & ~imr;

  pic_prio_resolver u_cand_res (
    .i_vec      (w_cand),
    .i_prio_low (prio_low),
    .o_level    (w_win_level),
    .o_found    (w_cand_found)
  );

  pic_prio_resolver u_isr_res (
    .i_vec      (r_isr),
    .i_prio_low (prio_low),
    .o_level    (w_isr_top),
    .o_found    (w_isr_found)
  );

  // Fully nested: winner must outrank every in-service level; special mask: only its own bit blocks.
  always_comb begin
    w_win_valid = 1'b0;
    if (w_cand_found) begin
      if (smm) begin
        w_win_valid = !r_isr[w_win_level];
      end else begin
        w_win_valid = !w_isr_found ||
                      (prio_rank(w_win_level, prio_low) < prio_rank(w_isr_top, prio_low));
      end
    end
  end

  assign w_take_ack = (r_state == PEND) && w_inta_fall && w_win_valid;
  assign w_ack_bit  = w_take_ack ? (8'b1 << w_win_level) : 8'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irr <= '0;
    end else if (ltim) begin
      r_irr <= w_irq_s;
    end else begin
      r_irr <= (r_irr | w_irq_rise) & w_irq_s & ~w_ack_bit;
    end
  end

  // A set from the first INTA overrides a same-cycle EOI clear of that bit.
  always_comb begin
    w_isr_clr = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        w_isr_clr = 8'b1 << eoi_level;
      end else if (w_isr_found) begin
        w_isr_clr = 8'b1 << w_isr_top;
      end
    end
`ifdef PIC_AEOI_EN
    if (aeoi && (r_state == ACK2) && w_inta_rise && !r_ack_spur) begin
      w_isr_clr = w_isr_clr | (8'b1 << r_ack_level);
    end
`endif
    w_isr_next = (r_isr & ~w_isr_clr) | w_ack_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_int       <= 1'b0;
      r_vec       <= '0;
      r_vec_oe    <= 1'b0;
      r_ack_level <= SPURIOUS_LEVEL;
      r_isr       <= '0;
`ifdef PIC_AEOI_EN
      r_ack_spur  <= 1'b0;
`endif
    end else begin
      r_isr <= w_isr_next;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_int   <= 1'b1;
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_inta_fall) begin
            r_int       <= 1'b0;
            r_ack_level <= w_win_valid ? w_win_level : SPURIOUS_LEVEL;
`ifdef PIC_AEOI_EN
            r_ack_spur  <= !w_win_valid;
`endif
            r_state     <= ACK1;
          end else if (!w_win_valid) begin
            r_int   <= 1'b0;
            r_state <= IDLE;
          end
        end
        ACK1: begin
          if (w_inta_rise) r_state <= GAP;
        end
        GAP: begin
          if (w_inta_fall) begin
            r_vec    <= {vec_base, r_ack_level};
            r_vec_oe <= 1'b1;
            r_state  <= ACK2;
          end
        end
        ACK2: begin
          if (w_inta_rise) begin
            r_vec    <= '0;
            r_vec_oe <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign int_o     = r_int;
  assign vec_o     = r_vec;
  assign vec_oe    = r_vec_oe;
  assign irr_o     = r_irr;
  assign isr_o     = r_isr;
  assign ack_level = r_ack_level;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Directed bench for pic_irq_sequencer; AEOI scenario only when PIC_AEOI_EN is defined.
module tb_pic_irq_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq = 8'h00;
  logic       ltim = 1'b0;
  logic [7:0] imr = 8'h00;
  logic       smm = 1'b0;
  logic [4:0] vec_base = 5'h08;
  logic [2:0] prio_low = 3'd7;
  logic       inta_n = 1'b1;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
`ifdef PIC_AEOI_EN
  logic       aeoi = 1'b0;
`endif
  logic       int_o;
  logic [7:0] vec_o;
  logic       vec_oe;
  logic [7:0] irr_o;
  logic [7:0] isr_o;
  logic [2:0] ack_level;
  logic [2:0] dbg_state;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  pic_irq_sequencer #(.SYNC_STAGES(2), .VEC_HI_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .ltim         (ltim),
    .imr          (imr),
    .smm          (smm),
    .vec_base     (vec_base),
    .prio_low     (prio_low),
    .inta_n       (inta_n),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
`ifdef PIC_AEOI_EN
    .aeoi         (aeoi),
`endif
    .int_o        (int_o),
    .vec_o        (vec_o),
    .vec_oe       (vec_oe),
    .irr_o        (irr_o),
    .isr_o        (isr_o),
    .ack_level    (ack_level),
    .dbg_state    (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    step(1);
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
  endtask

  // First INTA pulse: ISR set, level latched, INT dropped.
  task automatic ack_first(input string tag, input logic [7:0] exp_isr, input logic [2:0] exp_lvl);
    inta_n = 1'b0;
    step(4);
    chk({tag, "_isr1"}, isr_o, exp_isr);
    chk({tag, "_lvl"}, ack_level, exp_lvl);
    chk({tag, "_int_lo"}, int_o, 1'b0);
    chk({tag, "_st_ack1"}, dbg_state, 3'(ACK1));
    inta_n = 1'b1;
    step(4);
    chk({tag, "_st_gap"}, dbg_state, 3'(GAP));
  endtask

  // Second INTA pulse: vector driven only while it is low.
  task automatic ack_second(input string tag, input logic [7:0] exp_vec, input logic [7:0] exp_isr);
    logic [7:0] e;
    exp_q.push_back(exp_vec);
    inta_n = 1'b0;
    step(4);
    e = exp_q.pop_front();
    chk({tag, "_oe_hi"}, vec_oe, 1'b1);
    chk({tag, "_vec"}, vec_o, e);
    inta_n = 1'b1;
    step(4);
    chk({tag, "_oe_lo"}, vec_oe, 1'b0);
    chk({tag, "_vec_clr"}, vec_o, 8'h00);
    chk({tag, "_isr2"}, isr_o, exp_isr);
    chk({tag, "_st_idle"}, dbg_state, 3'(IDLE));
  endtask

  initial begin
    // reset values
    step(1);
    chk("rst_int", int_o, 1'b0);
    chk("rst_vec", vec_o, 8'h00);
    chk("rst_oe", vec_oe, 1'b0);
    chk("rst_irr", irr_o, 8'h00);
    chk("rst_isr", isr_o, 8'h00);
    chk("rst_lvl", ack_level, 3'd7);
    chk("rst_st", dbg_state, 3'(IDLE));
    reset = 1'b1;
    step(2);

    // 1: single edge on IR3, latency and vector
    irq = 8'h08;
    step(3);
    chk("t1_irr", irr_o, 8'h08);
    chk("t1_int_early", int_o, 1'b0);
    step(1);
    chk("t1_int", int_o, 1'b1);
    ack_first("t1", 8'h08, 3'd3);
    chk("t1_irr_clr", irr_o, 8'h00);
    ack_second("t1", 8'h43, 8'h08);
    irq = 8'h00;
    do_eoi(1'b0, 3'd0);
    chk("t1_eoi", isr_o, 8'h00);
    step(2);

    // 2: simultaneous IR2/IR5 with rotation, then non-specific EOI
    prio_low = 3'd2;
    irq = 8'h24;
    step(4);
    chk("t2_int", int_o, 1'b1);
    ack_first("t2a", 8'h20, 3'd5);
    ack_second("t2a", 8'h45, 8'h20);
    step(2);
    chk("t2_blocked", int_o, 1'b0);
    chk("t2_irr", irr_o, 8'h04);
    do_eoi(1'b0, 3'd0);
    chk("t2_eoi", isr_o, 8'h00);
    chk("t2_int_lag", int_o, 1'b0);
    step(1);
    chk("t2_int_ir2", int_o, 1'b1);
    ack_first("t2b", 8'h04, 3'd2);
    ack_second("t2b", 8'h42, 8'h04);
    irq = 8'h00;
    do_eoi(1'b0, 3'd0);
    chk("t2_eoi2", isr_o, 8'h00);
    step(2);

    // 3: special mask mode lets a lower level through
    prio_low = 3'd7;
    irq = 8'h01;
    step(4);
    chk("t3_int0", int_o, 1'b1);
    ack_first("t3a", 8'h01, 3'd0);
    ack_second("t3a", 8'h40, 8'h01);
    irq = 8'h11;
    step(5);
    chk("t3_nested_block", int_o, 1'b0);
    chk("t3_irr", irr_o, 8'h10);
    smm = 1'b1;
    step(1);
    chk("t3_smm_int", int_o, 1'b1);
    ack_first("t3b", 8'h11, 3'd4);
    ack_second("t3b", 8'h44, 8'h11);
    smm = 1'b0;
    irq = 8'h00;
    do_eoi(1'b0, 3'd0);
    chk("t3_eoi_a", isr_o, 8'h10);
    do_eoi(1'b0, 3'd0);
    chk("t3_eoi_b", isr_o, 8'h00);
    step(2);

    // 4: request withdrawn as INTA arrives -> spurious level 7
    irq = 8'h40;
    step(4);
    chk("t4_int", int_o, 1'b1);
    irq = 8'h00;
    step(1);
    ack_first("t4", 8'h00, 3'd7);
    ack_second("t4", 8'h47, 8'h00);
    step(2);

    // 5: specific EOI colliding with the ISR set, then specific retire
    irq = 8'h08;
    step(4);
    chk("t5_int", int_o, 1'b1);
    inta_n = 1'b0;
    step(2);
    eoi_valid = 1'b1;
    eoi_specific = 1'b1;
    eoi_level = 3'd3;
    step(1);
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    chk("t5_set_wins", isr_o, 8'h08);
    chk("t5_st", dbg_state, 3'(ACK1));
    step(1);
    inta_n = 1'b1;
    step(4);
    ack_second("t5a", 8'h43, 8'h08);
    irq = 8'h0A;
    step(4);
    chk("t5_int1", int_o, 1'b1);
    ack_first("t5b", 8'h0A, 3'd1);
    ack_second("t5b", 8'h41, 8'h0A);
    do_eoi(1'b1, 3'd1);
    chk("t5_spec1", isr_o, 8'h08);
    do_eoi(1'b1, 3'd3);
    chk("t5_spec3", isr_o, 8'h00);
    irq = 8'h00;
    step(3);

    // 6: reset in GAP, stray INTA afterwards
    irq = 8'h04;
    step(4);
    chk("t6_int", int_o, 1'b1);
    ack_first("t6", 8'h04, 3'd2);
    reset = 1'b0;
    irq = 8'h00;
    #1;
    chk("t6_rst_int", int_o, 1'b0);
    chk("t6_rst_oe", vec_oe, 1'b0);
    chk("t6_rst_vec", vec_o, 8'h00);
    chk("t6_rst_isr", isr_o, 8'h00);
    chk("t6_rst_irr", irr_o, 8'h00);
    chk("t6_rst_lvl", ack_level, 3'd7);
    chk("t6_rst_st", dbg_state, 3'(IDLE));
    step(2);
    reset = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(4);
    chk("t6_stray_st", dbg_state, 3'(IDLE));
    inta_n = 1'b1;
    step(4);
    inta_n = 1'b0;
    step(4);
    chk("t6_stray_oe", vec_oe, 1'b0);
    inta_n = 1'b1;
    step(4);
    chk("t6_stray_oe2", vec_oe, 1'b0);
    chk("t6_stray_isr", isr_o, 8'h00);

`ifdef PIC_AEOI_EN
    aeoi = 1'b1;
    irq = 8'h04;
    step(4);
    chk("t6_aeoi_int", int_o, 1'b1);
    ack_first("t6a", 8'h04, 3'd2);
    ack_second("t6a", 8'h42, 8'h00);
    irq = 8'h00;
    aeoi = 1'b0;
    step(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_irq_sequencer.md
Name: pic_irq_sequencer

Overview:
Clocked interrupt sequencer for the 8259-style controller. It captures raw IR lines into an IRR, resolves priority against IMR/ISR with rotating priority, and raises INT. It runs the two-pulse INTA handshake, sets ISR on the first pulse and drives the vector on the second. It also retires ISR bits on EOI commands. It sits between the register/command core (which supplies IMR, mode bits, vector base and EOI commands) and the CPU-side INT/INTA/data pins.

Parameters:
SYNC_STAGES, 2, flip-flop stages on irq[7:0] and inta_n before use (min 1)
VEC_HI_W, 5, width of vector base (upper vector bits), fixed at 5 for the 8-input variant

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
irq  in  8  raw interrupt request lines, asynchronous
ltim  in  1  1 = level-triggered, 0 = edge-triggered
imr  in  8  mask bits, 1 = masked
smm  in  1  special mask mode
vec_base  in  5  vector bits [7:3]
prio_low  in  3  current lowest-priority IR; highest = prio_low+1 mod 8
inta_n  in  1  CPU acknowledge strobe, active-low, asynchronous
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = specific EOI using eoi_level
eoi_level  in  3  IR level for specific EOI
int_o  out  1  interrupt request to CPU
vec_o  out  8  vector {vec_base, level}
vec_oe  out  1  vector drive enable
irr_o  out  8  interrupt request register
isr_o  out  8  in-service register
ack_level  out  3  level latched at first INTA

Behaviour:
- Reset (reset=0): int_o=0, vec_o=0, vec_oe=0, irr_o=0, isr_o=0, ack_level=7, state=IDLE, synchronizers cleared (inta_n sync chain preset to 1).
- IRR, edge mode: a bit sets on a synchronized 0->1 of irq. It clears when synchronized irq is 0, or at the first INTA falling edge for the acked level.
- IRR, level mode: IRR equals synchronized irq. The ack clears nothing.
- Resolution (combinational): cand = irr & ~imr. Scan from prio_low+1 upward mod 8; the first set bit wins. A winner is valid if its priority is strictly higher than the highest ISR bit.
- With smm=1, ISR bits do not block other levels; only the winner's own ISR bit blocks it.
- INTA edges are detected on the synchronized inta_n: fall = prev 1, now 0; rise = prev 0, now 1.
- FSM states: IDLE, PEND, ACK1, GAP, ACK2.
  - IDLE: if a valid winner exists, go to PEND and set int_o=1 (registered, next cycle).
  - PEND:
    - If the winner disappears before fall: int_o=0, go to IDLE.
    - On fall with a valid winner: ack_level=winner, isr[winner]=1, clear the edge-mode IRR bit, int_o=0, go to ACK1.
    - On fall with no winner (spurious): ack_level=7, ISR unchanged, int_o=0, go to ACK1.
  - ACK1: on rise, go to GAP.
  - GAP: on fall, vec_o={vec_base, ack_level}, vec_oe=1, go to ACK2.
  - ACK2: on rise, vec_oe=0, vec_o=0, go to IDLE.
- A fall in IDLE is ignored.
- IRR keeps updating in every state. Resolution is only sampled in IDLE and PEND.
- EOI (any state, eoi_valid=1):
  - Non-specific: clear the highest-priority set ISR bit under the current rotation.
  - Specific: clear isr[eoi_level].
  - If an ISR clear and a set hit the same bit in one cycle, the set wins.
- Latency:
  - irq edge to int_o high: SYNC_STAGES+2 cycles.
  - inta_n fall to ISR update: SYNC_STAGES+1 cycles.
- Reset asserted mid-handshake: immediate return to reset values. A later stray INTA rise is ignored in IDLE.

Optional Feature:
PIC_AEOI_EN.
- Defined: adds input port aeoi (1 bit). When aeoi=1, isr[ack_level] clears on the ACK2 rise (automatic EOI). A spurious ack (level 7, ISR not set) clears nothing.
- Undefined: the port is absent and ISR clears only via eoi_valid.

Decomposition:
- Package pic_pkg holds:
  - state enum (IDLE, PEND, ACK1, GAP, ACK2)
  - constants NUM_IR=8, SPURIOUS_LEVEL=3'd7
  - function rot_highest(vec, prio_low) returning level and a found flag
- Sub-module pic_prio_resolver: purely combinational rotating find-first. It is instantiated twice: once for cand selection and once for the non-specific EOI ISR search.

Test Plan:
1. Reset, prio_low=7, vec_base=5'h08, ltim=0. Pulse irq[3] 0->1 -> int_o=1 after 4 cycles. Two INTA pulses -> isr_o=8'h08, irr_o[3]=0, vec_o=8'h43 with vec_oe=1 during the 2nd pulse only.
2. irq=8'h24 simultaneously, prio_low=2 -> IR5 wins first (vec 8'h45, isr=8'h20). A non-specific EOI then clears isr=8'h00, and the next cycle serves IR2.
3. isr=8'h01 (IR0 in service), irq[4] rises, smm=0 -> int_o stays 0. Set smm=1 -> int_o=1 and the ack yields isr=8'h11.
4. int_o=1 for irq[6] edge mode, irq[6] drops before INTA, INTA pulses anyway -> vec_o=8'h47 (spurious), isr unchanged 8'h00.
5. Specific EOI eoi_level=3 issued in the same cycle ISR sets bit 3 -> isr_o[3]=1. eoi_level=1 with isr=8'h0A -> isr=8'h08.
6. Pull reset low during GAP -> all outputs 0 and state IDLE at once. Following INTA pulses produce no vec_oe. With PIC_AEOI_EN and aeoi=1, a full ack of IR2 leaves isr_o=8'h00 after the 2nd rise.
